// File: rtl/counter_prog_if.sv
// counter_prog_if: control/status bundle for the programmable counter.
//   slave  modport: used by counter_prog (takes the *_i controls, drives the *_o status)
//   master modport: used by whatever drives the counter (bench or host block)
//   Controls : flag_cnt_i, dir_i, mode_i, end_val_i, load_i, load_val_i, clr_i
//   Status   : cnt_o, end_cnt_o, busy_o, done_o, wrap_cnt_o
interface counter_prog_if #(
  parameter int CNT_WIDTH  = 8,
  parameter int WRAP_WIDTH = 8
);
  logic                  flag_cnt_i;
  logic                  dir_i;
  logic                  mode_i;
  logic [CNT_WIDTH-1:0]  end_val_i;
  logic                  load_i;
  logic [CNT_WIDTH-1:0]  load_val_i;
  logic                  clr_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  end_cnt_o;
  logic                  busy_o;
  logic                  done_o;
  logic [WRAP_WIDTH-1:0] wrap_cnt_o;

  modport slave (
    input  flag_cnt_i, dir_i, mode_i, end_val_i, load_i, load_val_i, clr_i,
    output cnt_o, end_cnt_o, busy_o, done_o, wrap_cnt_o
  );

  modport master (
    output flag_cnt_i, dir_i, mode_i, end_val_i, load_i, load_val_i, clr_i,
    input  cnt_o, end_cnt_o, busy_o, done_o, wrap_cnt_o
  );
endinterface

// File: rtl/counter_prog.sv
// counter_prog: programmable up/down counter with terminal value, auto-reload or
// one-shot mode, synchronous load/clear and a saturating terminal-event count.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : counter_prog_if.slave (controls in, count/status out; all outputs registered)
// Edge priority: rst > clr_i > load_i > counting.
module counter_prog #(
  parameter int CNT_WIDTH  = 8,
  parameter int WRAP_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  counter_prog_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WRAP_WIDTH-1:0] wrap_q, wrap_d;
  logic                  end_q, end_d;
  logic                  busy_q, done_q;
  logic                  term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wrap_q  <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      end_q   <= end_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    term    = 1'b0;
    if (bus.clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      wrap_d  = '0;
    end else if (bus.load_i) begin
      // load never advances nor compares on its own edge
      state_d = RUN;
      cnt_d   = bus.load_val_i;
    end else if (bus.flag_cnt_i && state_q != DONE) begin
      if (state_q == IDLE && bus.dir_i) begin
        // down count starts by fetching the start value, no compare yet
        state_d = RUN;
        cnt_d   = bus.end_val_i;
      end else begin
        state_d = RUN;
        // >= so a terminal value lowered below the count still terminates
        term = bus.dir_i ? (cnt_q == '0) : (cnt_q >= bus.end_val_i);
        if (!term)
          cnt_d = bus.dir_i ? cnt_q - CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
        else if (!bus.mode_i)
          cnt_d = bus.dir_i ? bus.end_val_i : '0;
        else
          state_d = DONE;   // one-shot: count holds at terminal
      end
    end
    if (term && !(&wrap_q))
      wrap_d = wrap_q + WRAP_WIDTH'(1);
    end_d = term;
  end

  assign bus.cnt_o      = cnt_q;
  assign bus.end_cnt_o  = end_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.wrap_cnt_o = wrap_q;

endmodule

// File: tb/tb_counter_prog.sv
module tb_counter_prog;
  localparam int CW = 4;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  // reference model state
  int m_cnt, m_wrap;
  bit m_end, m_run, m_fin;

  counter_prog_if #(.CNT_WIDTH(CW), .WRAP_WIDTH(WW)) bus ();

  counter_prog #(.CNT_WIDTH(CW), .WRAP_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of one clock edge, from the rules in plain arithmetic.
  task automatic model_edge();
    int mx;
    bit t;
    mx = 1 << CW;
    t  = 1'b0;
    if (rst || bus.clr_i) begin
      m_cnt = 0; m_wrap = 0; m_end = 0; m_run = 0; m_fin = 0;
    end else if (bus.load_i) begin
      m_cnt = int'(bus.load_val_i); m_run = 1; m_fin = 0; m_end = 0;
    end else if (m_fin || !bus.flag_cnt_i) begin
      m_end = 0;
    end else if (!m_run && bus.dir_i) begin
      m_cnt = int'(bus.end_val_i); m_run = 1; m_end = 0;
    end else begin
      m_run = 1;
      t = bus.dir_i ? (m_cnt == 0) : (m_cnt >= int'(bus.end_val_i));
      if (!t)            m_cnt = (m_cnt + (bus.dir_i ? mx - 1 : 1)) % mx;
      else if (!bus.mode_i) m_cnt = bus.dir_i ? int'(bus.end_val_i) : 0;
      else begin m_fin = 1; m_run = 0; end
      m_end = t;
      if (t && m_wrap < (1 << WW) - 1) m_wrap++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.flag_cnt_i = 0; bus.dir_i = 0; bus.mode_i = 0; bus.end_val_i = '0;
    bus.load_i = 0; bus.load_val_i = '0; bus.clr_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.flag_cnt_i = 1; bus.end_val_i = 4'd9;
    step(); step(); step();
    do_reset();
    checks++; if (bus.cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt_o); end
    checks++; if (bus.end_cnt_o !== 1'b0) begin failures++; $display("FAIL reset_end got=%0b exp=0", bus.end_cnt_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done_o); end
    checks++; if (bus.wrap_cnt_o !== 2'd0) begin failures++; $display("FAIL reset_wrap got=%0d exp=0", bus.wrap_cnt_o); end
  endtask

  task automatic test_up_reload();
    do_reset();
    bus.end_val_i = 4'd5; bus.flag_cnt_i = 1;
    for (int i = 1; i <= 13; i++) begin
      step();
      checks++; if (bus.cnt_o !== CW'(i % 6)) begin failures++; $display("FAIL up_cnt step=%0d got=%0d exp=%0d", i, bus.cnt_o, i % 6); end
      checks++; if (bus.end_cnt_o !== (i % 6 == 0)) begin failures++; $display("FAIL up_end step=%0d got=%0b exp=%0b", i, bus.end_cnt_o, i % 6 == 0); end
      checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL up_busy step=%0d got=%0b exp=1", i, bus.busy_o); end
    end
    checks++; if (bus.wrap_cnt_o !== 2'd2) begin failures++; $display("FAIL up_wrap got=%0d exp=2", bus.wrap_cnt_o); end
  endtask

  task automatic test_down_oneshot();
    int exp_seq [7] = '{3, 2, 1, 0, 0, 0, 0};
    int pulses;
    pulses = 0;
    do_reset();
    bus.dir_i = 1; bus.mode_i = 1; bus.end_val_i = 4'd3; bus.flag_cnt_i = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.end_cnt_o === 1'b1) pulses++;
      checks++; if (bus.cnt_o !== CW'(exp_seq[i])) begin failures++; $display("FAIL dn_cnt step=%0d got=%0d exp=%0d", i, bus.cnt_o, exp_seq[i]); end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL dn_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.done_o !== 1'b1) begin failures++; $display("FAIL dn_done got=%0b exp=1", bus.done_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL dn_busy got=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_pause();
    int exp_seq [4] = '{3, 4, 5, 0};
    do_reset();
    bus.end_val_i = 4'd5; bus.flag_cnt_i = 1;
    step(); step();
    bus.flag_cnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.cnt_o !== 4'd2) begin failures++; $display("FAIL pause_hold got=%0d exp=2", bus.cnt_o); end
      checks++; if (bus.end_cnt_o !== 1'b0) begin failures++; $display("FAIL pause_end got=%0b exp=0", bus.end_cnt_o); end
    end
    bus.flag_cnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.cnt_o !== CW'(exp_seq[i])) begin failures++; $display("FAIL pause_cnt got=%0d exp=%0d", bus.cnt_o, exp_seq[i]); end
      checks++; if (bus.end_cnt_o !== (i == 3)) begin failures++; $display("FAIL pause_pulse got=%0b exp=%0b", bus.end_cnt_o, i == 3); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.end_val_i = 4'd5; bus.flag_cnt_i = 1;
    step(); step();
    bus.load_i = 1; bus.load_val_i = 4'd4; bus.clr_i = 1;
    step();
    bus.clr_i = 0; bus.load_i = 0; bus.flag_cnt_i = 0;
    checks++; if (bus.cnt_o !== 4'd0) begin failures++; $display("FAIL prio_clr_cnt got=%0d exp=0", bus.cnt_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL prio_clr_busy got=%0b exp=0", bus.busy_o); end
    bus.load_i = 1;
    step();
    bus.load_i = 0; bus.flag_cnt_i = 1;
    checks++; if (bus.cnt_o !== 4'd4) begin failures++; $display("FAIL prio_load got=%0d exp=4", bus.cnt_o); end
    checks++; if (bus.end_cnt_o !== 1'b0) begin failures++; $display("FAIL prio_load_end got=%0b exp=0", bus.end_cnt_o); end
    step();
    checks++; if (bus.cnt_o !== 4'd5) begin failures++; $display("FAIL prio_cnt5 got=%0d exp=5", bus.cnt_o); end
    step();
    checks++; if (bus.cnt_o !== 4'd0 || bus.end_cnt_o !== 1'b1) begin failures++; $display("FAIL prio_wrap got=%0d/%0b exp=0/1", bus.cnt_o, bus.end_cnt_o); end
    // end_val 0 one-shot terminates on the first compare
    bus.mode_i = 1; bus.end_val_i = 4'd0;
    step();
    checks++; if (bus.done_o !== 1'b1) begin failures++; $display("FAIL prio_done got=%0b exp=1", bus.done_o); end
    bus.load_i = 1; bus.load_val_i = 4'd2;
    step();
    bus.load_i = 0; bus.flag_cnt_i = 0;
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL prio_load_done got done=%0b busy=%0b exp done=0 busy=1", bus.done_o, bus.busy_o); end
    checks++; if (bus.cnt_o !== 4'd2 || bus.end_cnt_o !== 1'b0) begin failures++; $display("FAIL prio_load_val got=%0d/%0b exp=2/0", bus.cnt_o, bus.end_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.end_val_i = 4'd3; bus.flag_cnt_i = 1;
    for (int i = 0; i < 11; i++) step();
    checks++; if (bus.cnt_o !== 4'd3 || bus.wrap_cnt_o !== 2'd2) begin failures++; $display("FAIL mid_pre got cnt=%0d wrap=%0d exp cnt=3 wrap=2", bus.cnt_o, bus.wrap_cnt_o); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (bus.cnt_o !== 4'd0 || bus.wrap_cnt_o !== 2'd0 || bus.busy_o !== 1'b0 || bus.end_cnt_o !== 1'b0 || bus.done_o !== 1'b0)
      begin failures++; $display("FAIL mid_rst got cnt=%0d wrap=%0d busy=%0b end=%0b done=%0b exp all 0", bus.cnt_o, bus.wrap_cnt_o, bus.busy_o, bus.end_cnt_o, bus.done_o); end
    step();
    checks++; if (bus.cnt_o !== 4'd1) begin failures++; $display("FAIL mid_restart got=%0d exp=1", bus.cnt_o); end
  endtask

  task automatic test_saturation();
    int exp_w [5] = '{1, 2, 3, 3, 3};
    do_reset();
    bus.end_val_i = 4'd0; bus.flag_cnt_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.wrap_cnt_o !== WW'(exp_w[i])) begin failures++; $display("FAIL sat_wrap step=%0d got=%0d exp=%0d", i, bus.wrap_cnt_o, exp_w[i]); end
      checks++; if (bus.end_cnt_o !== 1'b1 || bus.cnt_o !== 4'd0) begin failures++; $display("FAIL sat_end step=%0d got end=%0b cnt=%0d exp end=1 cnt=0", i, bus.end_cnt_o, bus.cnt_o); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 79) == 0);
      bus.clr_i      = ($urandom_range(0, 39) == 0);
      bus.load_i     = ($urandom_range(0, 19) == 0);
      bus.load_val_i = CW'($urandom_range(0, 15));
      bus.flag_cnt_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.dir_i  = ~bus.dir_i;
      if ($urandom_range(0, 15) == 0) bus.mode_i = ~bus.mode_i;
      if ($urandom_range(0, 7) == 0)  bus.end_val_i = CW'($urandom_range(0, 15));
      step();
      checks++; if (bus.cnt_o !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, bus.cnt_o, m_cnt); end
      checks++; if (bus.end_cnt_o !== m_end) begin failures++; $display("FAIL rnd_end cyc=%0d got=%0b exp=%0b", i, bus.end_cnt_o, m_end); end
      checks++; if (bus.busy_o !== m_run) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", i, bus.busy_o, m_run); end
      checks++; if (bus.done_o !== m_fin) begin failures++; $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", i, bus.done_o, m_fin); end
      checks++; if (bus.wrap_cnt_o !== WW'(m_wrap)) begin failures++; $display("FAIL rnd_wrap cyc=%0d got=%0d exp=%0d", i, bus.wrap_cnt_o, m_wrap); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_up_reload();
    test_down_oneshot();
    test_pause();
    test_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_prog.md
Name: counter_prog

Overview:
Parametrised successor to the basic free-running counter used across our benches and DUTs.
- Adds a programmable terminal value, up/down direction, auto-reload or one-shot mode, synchronous load/clear, and a saturating count of terminal events.
- Still provides the `cnt_o` / `end_cnt_o` pair, so existing testbench tasks that wait on `@(posedge end_cnt)` keep working.
- Sits beside protocol blocks such as tx_trans, as a programmable timebase.

Parameters:
- CNT_WIDTH, 8, width of the count register and of `end_val_i` / `load_val_i`.
- WRAP_WIDTH, 8, width of the terminal-event counter `wrap_cnt_o`.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flag_cnt_i  input  1  count enable; 1 = advance this cycle, 0 = hold.
- dir_i  input  1  0 = count up, 1 = count down; sampled live every cycle.
- mode_i  input  1  0 = auto-reload (wrap), 1 = one-shot; sampled live.
- end_val_i  input  CNT_WIDTH  terminal value in up mode, start value in down mode; sampled live.
- load_i  input  1  synchronous load strobe.
- load_val_i  input  CNT_WIDTH  value written to the count on `load_i`.
- clr_i  input  1  synchronous clear strobe.
- cnt_o  output  CNT_WIDTH  current count (registered).
- end_cnt_o  output  1  one-cycle terminal-event pulse (registered).
- busy_o  output  1  high while the FSM is in RUN.
- done_o  output  1  sticky; one-shot has completed.
- wrap_cnt_o  output  WRAP_WIDTH  saturating number of terminal events.

Behaviour:
- Reset and clear:
  - `rst` = 1 at an edge: `cnt_o` = 0, `end_cnt_o` = 0, `busy_o` = 0, `done_o` = 0, `wrap_cnt_o` = 0, FSM goes to IDLE.
  - `clr_i` has the same effect as `rst`.
- Priority per edge: `rst` > `clr_i` > `load_i` > counting.
- Load:
  - `load_i` sets `cnt_o` = `load_val_i`, clears `done_o`, and moves the FSM to RUN.
  - No count advance and no terminal check occur on a load cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `flag_cnt_i` = 0: hold.
  - `flag_cnt_i` = 1, up mode: behaves exactly as RUN, including the terminal check on 0; FSM goes to RUN.
  - `flag_cnt_i` = 1, down mode: `cnt_o` = `end_val_i`, FSM goes to RUN; no terminal check that cycle.
- RUN:
  - `flag_cnt_i` = 0: hold.
  - `flag_cnt_i` = 1: evaluate the terminal condition on the current `cnt_o`.
    - Up terminal condition: `cnt_o` >= `end_val_i`. The >= form covers `end_val_i` lowered mid-run.
    - Down terminal condition: `cnt_o` == 0.
    - Not terminal: `cnt_o` +1 (up) or −1 (down), modulo 2^CNT_WIDTH.
    - Terminal, `mode_i` = 0: `cnt_o` reloads (up → 0, down → `end_val_i`); FSM stays in RUN.
    - Terminal, `mode_i` = 1: `cnt_o` holds its value, `done_o` = 1, FSM goes to DONE.
- On every terminal event:
  - `end_cnt_o` is 1 for exactly the following cycle.
  - `wrap_cnt_o` increments, saturating at all-ones (no wrap).
- Resulting period in auto-reload up mode: `end_val_i` + 1 enabled cycles.
- DONE:
  - `flag_cnt_i` is ignored; `cnt_o` holds.
  - Exit only via `rst`, `clr_i`, or `load_i` (load goes to RUN).
- `busy_o` = (state == RUN); `done_o` = (state == DONE). Both are registered.
- Mid-run changes:
  - A change of `dir_i` or `mode_i` takes effect on the next enabled cycle.
  - A change of `end_val_i` takes effect on the next compare or reload.
- `end_val_i` = 0:
  - Up mode: terminal on every enabled cycle; `end_cnt_o` is high continuously while enabled.
  - Down mode: same behaviour.
- `end_cnt_o` is never asserted on a cycle following a `rst`, `clr_i`, or `load_i` edge.

Test Plan:
1. Up, auto-reload: CNT_WIDTH=4, `end_val_i`=5, `mode_i`=0. Release `rst`, hold `flag_cnt_i`=1 → `cnt_o` 0,1,2,3,4,5,0,1…; `end_cnt_o` is 1 in each cycle `cnt_o` returns to 0 (every 6 cycles); `wrap_cnt_o` 1, 2, …; `busy_o`=1.
2. Down, one-shot: `dir_i`=1, `mode_i`=1, `end_val_i`=3, `flag_cnt_i`=1 → `cnt_o` 0,3,2,1,0 then holds 0; exactly one `end_cnt_o` pulse; `done_o`=1, `busy_o`=0; further enable has no effect.
3. Pause: in scenario 1, drop `flag_cnt_i` for 3 cycles at `cnt_o`=2 → `cnt_o` holds 2, no pulse; on re-enable → 3, 4, 5, 0 with one pulse.
4. Priority:
   - `load_i`=1 with `load_val_i`=4 and `clr_i`=1 on the same edge → `cnt_o`=0, state IDLE.
   - `load_i` alone with `load_val_i`=4 (up, `end_val_i`=5) → `cnt_o` 4, 5, 0, one pulse.
   - `load_i` in DONE → `done_o` clears, `busy_o`=1.
5. Reset mid-run: assert `rst` at `cnt_o`=3 with `wrap_cnt_o`=2 → next cycle all outputs are 0 and state is IDLE; counting restarts from 0 after release.
6. Saturation: WRAP_WIDTH=2, `end_val_i`=0, `flag_cnt_i`=1 → `end_cnt_o` held high; `wrap_cnt_o` 1, 2, 3, 3, 3; `cnt_o` stays 0.
